pipe_scroller: RTL
==================

Name: pipe_scroller

Overview:
- Generates and scrolls the four obstacle pipes consumed by the bird/collision logic (Pipe1X/Y..Pipe4X/Y). Consumes GAME_END from the bird block to freeze the field.
- Runs on the frame clock, one update per frame, and is keyboard-controlled (start/stop/restart).
- Pipe X is the pipe centre column. Pipe Y is the gap centre row. The bird side uses a half-width of 25 and a gap half-height of 75 around these values.

Parameters:
- START_X, 400, Pipe1X after reset or restart; pipe n starts at START_X + (n-1)*SPACING.
- SPACING, 160, horizontal distance between consecutive pipes; the wrap distance is 4*SPACING = 640.
- GAP_Y_RESET, 240, gap centre of all pipes after reset or restart.
- GAP_Y_BASE, 110, offset added to the LFSR value when a pipe is re-spawned.
- SPEED_INIT, 2, pixels per frame at run start.
- SPEED_MAX, 6, speed saturation value.
- WRAPS_PER_STEP, 8, number of pipe wraps between speed increments.
- LFSR_SEED, 8'hA5, non-zero LFSR reset value.

Ports:
- frame_clk  in  1  frame clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  8  keyboard code: 8'h2C space (start), 8'h16 S (stop), 8'h15 R (restart).
- GAME_END  in  1  collision/game-over flag from the bird block; level-sensitive.
- Pipe1X, Pipe2X, Pipe3X, Pipe4X  out  10 each  pipe centre X, registered.
- Pipe1Y, Pipe2Y, Pipe3Y, Pipe4Y  out  10 each  gap centre Y, registered.
- Running  out  1  high while in RUN.
- Speed  out  4  current scroll speed in pixels/frame.

Behaviour:
- Reset (synchronous, checked first, overrides everything):
  - state=IDLE.
  - PipenX = START_X + (n-1)*SPACING, giving 400/560/720/880.
  - All PipenY = GAP_Y_RESET.
  - Speed = SPEED_INIT, wrap counter = 0, lfsr = LFSR_SEED, Running = 0.
- "Field reset" means the same actions minus the LFSR; the LFSR keeps running.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1), shifted left each frame with the feedback bit entering bit0.
  - Advances every frame in every state except Reset, so it never reaches 0.
- States, all registered:
  - IDLE:
    - Pipes static.
    - keycode==8'h2C and GAME_END==0 → RUN; the first motion occurs on the following frame.
    - Space while GAME_END==1 is ignored.
  - RUN, evaluated in priority order:
    - (1) GAME_END==1 → OVER; no motion on this frame.
    - (2) keycode==8'h16 or 8'h15 → field reset, → IDLE.
    - (3) Otherwise every pipe moves.
  - OVER:
    - All outputs frozen.
    - keycode==8'h15 → field reset, → IDLE.
    - All other keys ignored; GAME_END deasserting alone does not leave OVER.
- Motion, per pipe, each RUN frame:
  - If PipenX > Speed: PipenX -= Speed.
  - Else (wrap): PipenX = PipenX - Speed + 4*SPACING, computed in 10-bit modulo-1024 arithmetic, which stays in range by construction. The pipe also re-spawns: PipenY = GAP_Y_BASE + lfsr (current value, zero-extended), giving a range of 111..365.
  - Because SPACING > SPEED_MAX, at most one pipe wraps per frame. Two pipes wrapping together is illegal configuration; no arbitration is required.
- Speed ramp:
  - Each wrap increments the wrap counter (4 bits).
  - When the counter reaches WRAPS_PER_STEP it clears to 0, and Speed = min(Speed+1, SPEED_MAX).
  - The ramp is applied on the same frame as the wrap; the new speed is used from the next frame.
  - Speed and the wrap counter return to initial values on field reset.
- Running = (state==RUN), registered with the state.
- Unknown keycodes, including 8'h00, have no effect in any state.

Test Plan:
1. Assert Reset 2 frames → Pipe1..4X = 400/560/720/880, all Y = 240, Speed=2, Running=0. Hold keycode=0 for 10 frames → no change.
2. Idle, keycode=8'h2C for 1 frame → Running=1 the next frame, Pipe1X=398 the frame after, and 396 one frame later.
3. RUN until Pipe1X=2, then step once → Pipe1X=640, Pipe1Y=110+lfsr (model the LFSR from seed 8'hA5). Pipe2X..4X each decrease by 2 on the same frame.
4. Run through 8 wraps → Speed becomes 3 the frame after the 8th wrap. Continue to 32 wraps → Speed=6 and holds at 6.
5. RUN with GAME_END=1 → state OVER, Running=0, all X/Y unchanged for 20 frames. Keys 2C and 16 are ignored. Key 15 → positions 400/560/720/880, Y=240, Speed=2, state IDLE.
6. Corner cases:
   - Reset in RUN mid-scroll → full reset values on the next frame.
   - In IDLE with GAME_END=1, key 2C → stays IDLE.
   - Key 16 in RUN → IDLE with the field reset.

Source files
------------

// File: rtl/pipe_scroller_if.sv
// ============================================================================
// pipe_scroller_if : keyboard/game-over inputs and pipe field outputs
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pipe_scroller_if;
  logic [7:0] keycode;
  logic       GAME_END;
  logic [9:0] Pipe1X;
  logic [9:0] Pipe2X;
  logic [9:0] Pipe3X;
  logic [9:0] Pipe4X;
  logic [9:0] Pipe1Y;
  logic [9:0] Pipe2Y;
  logic [9:0] Pipe3Y;
  logic [9:0] Pipe4Y;
  logic       Running;
  logic [3:0] Speed;

  // Pipe generator side
  modport master (
    input  keycode, GAME_END,
    output Pipe1X, Pipe2X, Pipe3X, Pipe4X,
    output Pipe1Y, Pipe2Y, Pipe3Y, Pipe4Y,
    output Running, Speed
  );

  // Consumer side (bird/collision logic, keyboard)
  modport slave (
    output keycode, GAME_END,
    input  Pipe1X, Pipe2X, Pipe3X, Pipe4X,
    input  Pipe1Y, Pipe2Y, Pipe3Y, Pipe4Y,
    input  Running, Speed
  );
endinterface

`default_nettype wire

// File: rtl/pipe_scroller.sv
// ============================================================================
// pipe_scroller : four-pipe obstacle field, scrolled once per frame
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_scroller #(
  parameter int         START_X        = 400,
  parameter int         SPACING        = 160,
  parameter int         GAP_Y_RESET    = 240,
  parameter int         GAP_Y_BASE     = 110,
  parameter int         SPEED_INIT     = 2,
  parameter int         SPEED_MAX      = 6,
  parameter int         WRAPS_PER_STEP = 8,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic             frame_clk,
  input  logic             Reset,
  pipe_scroller_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_e;

  localparam logic [7:0] KEY_START   = 8'h2C;
  localparam logic [7:0] KEY_STOP    = 8'h16;
  localparam logic [7:0] KEY_RESTART = 8'h15;
  localparam logic [9:0] WRAP_DIST   = 10'(4 * SPACING);
  localparam logic [9:0] GAP_BASE    = 10'(GAP_Y_BASE);
  localparam logic [9:0] GAP_RESET   = 10'(GAP_Y_RESET);
  localparam logic [3:0] SPD_INIT    = 4'(SPEED_INIT);
  localparam logic [3:0] SPD_MAX     = 4'(SPEED_MAX);
  localparam logic [3:0] WRAP_LAST   = 4'(WRAPS_PER_STEP - 1);

  state_e     state_q, state_d;
  logic [9:0] px_q [4];
  logic [9:0] px_d [4];
  logic [9:0] py_q [4];
  logic [9:0] py_d [4];
  logic [3:0] speed_q, speed_d;
  logic [3:0] wrap_cnt_q, wrap_cnt_d;
  logic [7:0] lfsr_q, lfsr_d;

  logic       field_reset;
  logic       move;
  logic       wrap_any;
  logic [9:0] speed_ext;

  assign speed_ext = {6'd0, speed_q};

  always_comb begin
    state_d     = state_q;
    speed_d     = speed_q;
    wrap_cnt_d  = wrap_cnt_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    field_reset = 1'b0;
    move        = 1'b0;
    wrap_any    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      px_d[i] = px_q[i];
      py_d[i] = py_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.keycode == KEY_START && !bus.GAME_END) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.GAME_END) begin
          state_d = S_OVER;
        end else if (bus.keycode == KEY_STOP || bus.keycode == KEY_RESTART) begin
          field_reset = 1'b1;
          state_d     = S_IDLE;
        end else begin
          move = 1'b1;
        end
      end
      S_OVER: begin
        if (bus.keycode == KEY_RESTART) begin
          field_reset = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (move) begin
      for (int i = 0; i < 4; i++) begin
        if (px_q[i] > speed_ext) begin
          px_d[i] = px_q[i] - speed_ext;
        end else begin
          // Modulo-1024 arithmetic lands the result back in 1..640.
          px_d[i]  = px_q[i] - speed_ext + WRAP_DIST;
          py_d[i]  = GAP_BASE + {2'b00, lfsr_q};
          wrap_any = 1'b1;
        end
      end
      // Pipe spacing exceeds the max speed, so at most one wrap per frame.
      if (wrap_any) begin
        if (wrap_cnt_q == WRAP_LAST) begin
          wrap_cnt_d = 4'd0;
          speed_d    = (speed_q < SPD_MAX) ? speed_q + 4'd1 : SPD_MAX;
        end else begin
          wrap_cnt_d = wrap_cnt_q + 4'd1;
        end
      end
    end

    if (field_reset) begin
      speed_d    = SPD_INIT;
      wrap_cnt_d = 4'd0;
      for (int i = 0; i < 4; i++) begin
        px_d[i] = 10'(START_X + i * SPACING);
        py_d[i] = GAP_RESET;
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      speed_q    <= SPD_INIT;
      wrap_cnt_q <= 4'd0;
      lfsr_q     <= LFSR_SEED;
      for (int i = 0; i < 4; i++) begin
        px_q[i] <= 10'(START_X + i * SPACING);
        py_q[i] <= GAP_RESET;
      end
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      wrap_cnt_q <= wrap_cnt_d;
      lfsr_q     <= lfsr_d;
      for (int i = 0; i < 4; i++) begin
        px_q[i] <= px_d[i];
        py_q[i] <= py_d[i];
      end
    end
  end

  assign bus.Pipe1X  = px_q[0];
  assign bus.Pipe2X  = px_q[1];
  assign bus.Pipe3X  = px_q[2];
  assign bus.Pipe4X  = px_q[3];
  assign bus.Pipe1Y  = py_q[0];
  assign bus.Pipe2Y  = py_q[1];
  assign bus.Pipe3Y  = py_q[2];
  assign bus.Pipe4Y  = py_q[3];
  assign bus.Running = (state_q == S_RUN);
  assign bus.Speed   = speed_q;

endmodule

`default_nettype wire
